// File: rtl/pong_input_ctrl.sv
// pong_input_ctrl: turns the single-key keypad scanner stream into per-player
// paddle move strobes (with auto-repeat) plus start / pause game commands.
// Each tracked key keeps a hold timer that bridges the gaps between scanner
// sightings, so two players can share the one keypad.

module pong_input_ctrl #(
    parameter int HOLD_CYCLES   = 2048,
    parameter int REPEAT_CYCLES = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] keycode,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start,
    output logic       paused
);

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_LOAD  = RW'(REPEAT_CYCLES - 1);

    // Tracked key slots
    localparam int NUM_KEYS = 6;
    localparam int K_P1_UP  = 0;
    localparam int K_P1_DN  = 1;
    localparam int K_P2_UP  = 2;
    localparam int K_P2_DN  = 3;
    localparam int K_STAR   = 4;
    localparam int K_HASH   = 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2
    } move_state_t;

    // Scanner code for each tracked key slot
    function automatic logic [3:0] key_code(input int k);
        case (k)
            K_P1_UP: key_code = 4'd1;
            K_P1_DN: key_code = 4'd7;
            K_P2_UP: key_code = 4'd10;
            K_P2_DN: key_code = 4'd12;
            K_STAR:  key_code = 4'd14;
            K_HASH:  key_code = 4'd15;
            default: key_code = 4'd0;
        endcase
    endfunction

    logic [TW-1:0]       hold_timer [NUM_KEYS];
    logic [NUM_KEYS-1:0] sighted;
    logic [NUM_KEYS-1:0] held;

    logic [1:0]          dir_up;
    logic [1:0]          dir_dn;

    move_state_t         state   [2];
    logic [RW-1:0]       rep_cnt [2];
    logic [1:0]          up_q;
    logic [1:0]          dn_q;

    logic                held_star_d;
    logic                held_hash_d;

    // Decode the current scanner code against every tracked key and derive hold levels
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sighted = '0;
        held    = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            sighted[k] = keycode[0] && (keycode[4:1] == key_code(k));
            held[k]    = (hold_timer[k] != '0);
        end
    end

    // Hold timers: reload on a sighting, otherwise count down and stick at zero
    always_ff @(posedge clk) begin
        // NOTE: the timer array is small and must start cleared, so it is reset like any other register.
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                hold_timer[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                if (sighted[k]) begin
                    hold_timer[k] <= HOLD_LOAD;
                end else if (hold_timer[k] != '0) begin
                    hold_timer[k] <= hold_timer[k] - 1'b1;
                end
            end
        end
    end

    // Per-player direction: a conflicting up+down pair resolves to no direction
    always_comb begin
        dir_up    = '0;
        dir_dn    = '0;
        dir_up[0] = held[K_P1_UP] & ~held[K_P1_DN];
        dir_dn[0] = held[K_P1_DN] & ~held[K_P1_UP];
        dir_up[1] = held[K_P2_UP] & ~held[K_P2_DN];
        dir_dn[1] = held[K_P2_DN] & ~held[K_P2_UP];
    end

    // Per-player repeat FSMs: strobe on entry or reversal, then every REPEAT_CYCLES while held
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                state[p]   <= S_IDLE;
                rep_cnt[p] <= '0;
                up_q[p]    <= 1'b0;
                dn_q[p]    <= 1'b0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                // Strobes are single-cycle; pause masks them but the FSM keeps counting.
                up_q[p] <= 1'b0;
                dn_q[p] <= 1'b0;
                case (state[p])
                    S_IDLE: begin
                        if (dir_up[p]) begin
                            state[p]   <= S_MOVE_UP;
                            rep_cnt[p] <= REP_LOAD;
                            up_q[p]    <= ~paused;
                        end else if (dir_dn[p]) begin
                            state[p]   <= S_MOVE_DOWN;
                            rep_cnt[p] <= REP_LOAD;
                            dn_q[p]    <= ~paused;
                        end else begin
                            rep_cnt[p] <= '0;
                        end
                    end
                    S_MOVE_UP: begin
                        if (dir_dn[p]) begin
                            state[p]   <= S_MOVE_DOWN;
                            rep_cnt[p] <= REP_LOAD;
                            dn_q[p]    <= ~paused;
                        end else if (!dir_up[p]) begin
                            state[p]   <= S_IDLE;
                            rep_cnt[p] <= '0;
                        end else if (rep_cnt[p] == '0) begin
                            rep_cnt[p] <= REP_LOAD;
                            up_q[p]    <= ~paused;
                        end else begin
                            rep_cnt[p] <= rep_cnt[p] - 1'b1;
                        end
                    end
                    S_MOVE_DOWN: begin
                        if (dir_up[p]) begin
                            state[p]   <= S_MOVE_UP;
                            rep_cnt[p] <= REP_LOAD;
                            up_q[p]    <= ~paused;
                        end else if (!dir_dn[p]) begin
                            state[p]   <= S_IDLE;
                            rep_cnt[p] <= '0;
                        end else if (rep_cnt[p] == '0) begin
                            rep_cnt[p] <= REP_LOAD;
                            dn_q[p]    <= ~paused;
                        end else begin
                            rep_cnt[p] <= rep_cnt[p] - 1'b1;
                        end
                    end
                    default: begin
                        state[p]   <= S_IDLE;
                        rep_cnt[p] <= '0;
                    end
                endcase
            end
        end
    end

    // Commands: start pulses on the rising edge of held '*', pause toggles on held '#'
    always_ff @(posedge clk) begin
        if (rst) begin
            held_star_d <= 1'b0;
            held_hash_d <= 1'b0;
            start       <= 1'b0;
            paused      <= 1'b0;
        end else begin
            held_star_d <= held[K_STAR];
            held_hash_d <= held[K_HASH];
            start       <= held[K_STAR] & ~held_star_d;
            if (held[K_HASH] && !held_hash_d) begin
                paused <= ~paused;
            end
        end
    end

    assign p1_up   = up_q[0];
    assign p1_down = dn_q[0];
    assign p2_up   = up_q[1];
    assign p2_down = dn_q[1];

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Testbench for pong_input_ctrl with HOLD_CYCLES=8, REPEAT_CYCLES=20.
// Each scenario queues per-cycle stimulus together with the expected output
// vector for that cycle; the driver records what the DUT shows and the
// scenario compares the two queues entry by entry.

module tb_pong_input_ctrl;

    localparam int HOLD = 8;
    localparam int REP  = 20;

    // Output vector bit masks: {p1_up, p1_down, p2_up, p2_down, start, paused}
    localparam logic [5:0] B_P1U = 6'b100000;
    localparam logic [5:0] B_P1D = 6'b010000;
    localparam logic [5:0] B_P2U = 6'b001000;
    localparam logic [5:0] B_P2D = 6'b000100;
    localparam logic [5:0] B_ST  = 6'b000010;
    localparam logic [5:0] B_PA  = 6'b000001;

    typedef struct packed {
        logic       rst;
        logic [4:0] kc;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] keycode;
    logic       p1_up, p1_down, p2_up, p2_down, start, paused;
    logic [5:0] dut_out;

    stim_t      stim_q [$];
    logic [5:0] exp_q  [$];
    logic [5:0] obs_q  [$];

    int total = 0;
    int bad   = 0;

    pong_input_ctrl #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .keycode (keycode),
        .p1_up   (p1_up),
        .p1_down (p1_down),
        .p2_up   (p2_up),
        .p2_down (p2_down),
        .start   (start),
        .paused  (paused)
    );

    always #5 clk = ~clk;

    assign dut_out = {p1_up, p1_down, p2_up, p2_down, start, paused};

    function automatic logic [4:0] kv(input int code);
        logic [3:0] c;
        c = code[3:0];
        return {c, 1'b1};
    endfunction

    // Queue `count` cycles of one stimulus with an all-quiet expectation
    task automatic add_stim(input logic r, input logic [4:0] kc, input int count);
        stim_t s;
        s.rst = r;
        s.kc  = kc;
        for (int i = 0; i < count; i++) begin
            stim_q.push_back(s);
            exp_q.push_back(6'b000000);
        end
    endtask

    task automatic expect_bit(input int cyc, input logic [5:0] mask);
        exp_q[cyc] = exp_q[cyc] | mask;
    endtask

    // Sample the outputs at each falling edge, then apply that cycle's stimulus
    task automatic run();
        stim_t s;
        int    n;
        n = stim_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            obs_q.push_back(dut_out);
            s       = stim_q.pop_front();
            rst     = s.rst;
            keycode = s.kc;
        end
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        keycode = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b1, kv(1), 3);
        add_stim(1'b0, kv(1), 10);
        add_stim(1'b0, 5'd0, 17);
        expect_bit(5, B_P1U);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_single_hold();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b0, kv(1), 70);
        add_stim(1'b0, 5'd0, 30);
        expect_bit(2, B_P1U);
        expect_bit(22, B_P1U);
        expect_bit(42, B_P1U);
        expect_bit(62, B_P1U);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single_hold cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_conflict();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        for (int b = 0; b < 16; b++) begin
            add_stim(1'b0, (b % 2 == 0) ? kv(1) : kv(7), 4);
        end
        add_stim(1'b0, 5'd0, 26);
        // Only the solo windows before '7' first appears and after '1' expires can move.
        expect_bit(2, B_P1U);
        expect_bit(69, B_P1D);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL conflict cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_interleave();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        for (int b = 0; b < 20; b++) begin
            add_stim(1'b0, (b % 2 == 0) ? kv(10) : kv(1), 4);
        end
        add_stim(1'b0, 5'd0, 30);
        for (int i = 0; i < 5; i++) begin
            expect_bit(2 + REP * i, B_P2U);
            expect_bit(6 + REP * i, B_P1U);
        end
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL interleave cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reversal();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b0, kv(1), 10);
        add_stim(1'b0, 5'd0, 7);
        add_stim(1'b0, kv(7), 29);
        add_stim(1'b0, 5'd0, 24);
        // '7' first sighted exactly as '1' expires: direct reversal with a fresh repeat period.
        expect_bit(2, B_P1U);
        expect_bit(19, B_P1D);
        expect_bit(39, B_P1D);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL reversal cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_release_timeout();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b0, kv(12), 1);
        add_stim(1'b0, 5'd0, 19);
        // Re-sighting 8 cycles later keeps the hold alive.
        add_stim(1'b0, kv(12), 1);
        add_stim(1'b0, 5'd0, 7);
        add_stim(1'b0, kv(12), 1);
        add_stim(1'b0, 5'd0, 11);
        // Re-sighting 9 cycles later lets the hold lapse for one edge.
        add_stim(1'b0, kv(12), 1);
        add_stim(1'b0, 5'd0, 8);
        add_stim(1'b0, kv(12), 1);
        add_stim(1'b0, 5'd0, 20);
        expect_bit(2, B_P2D);
        expect_bit(22, B_P2D);
        expect_bit(42, B_P2D);
        expect_bit(51, B_P2D);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL release_timeout cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_pause();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b0, kv(15), 1);
        add_stim(1'b0, 5'd0, 4);
        add_stim(1'b0, kv(1), 6);
        add_stim(1'b0, kv(15), 1);
        add_stim(1'b0, kv(1), 48);
        add_stim(1'b0, 5'd0, 20);
        for (int c = 2; c <= 12; c++) begin
            expect_bit(c, B_PA);
        end
        expect_bit(27, B_P1U);
        expect_bit(47, B_P1U);
        expect_bit(67, B_P1U);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL pause cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_start();
        logic [5:0] e, o;
        int         cyc;
        reset_dut();
        add_stim(1'b0, kv(14), 30);
        add_stim(1'b0, 5'd0, 15);
        add_stim(1'b0, kv(14), 1);
        add_stim(1'b0, 5'd0, 14);
        expect_bit(2, B_ST);
        expect_bit(47, B_ST);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL start cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    task automatic test_untracked();
        logic [5:0] e, o;
        int         cyc;
        int         codes [10];
        int         tracked [6];
        logic [3:0] c;
        codes   = '{0, 2, 3, 4, 5, 6, 8, 9, 11, 13};
        tracked = '{1, 7, 10, 12, 14, 15};
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            add_stim(1'b0, kv(codes[i]), 3);
        end
        // Tracked codes with valid low must be ignored too.
        for (int i = 0; i < 6; i++) begin
            c = tracked[i][3:0];
            add_stim(1'b0, {c, 1'b0}, 2);
        end
        add_stim(1'b0, 5'd0, 10);
        run();
        cyc = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL untracked cyc=%0d got=%b want=%b", cyc, o, e);
            end
            cyc++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        keycode = 5'd0;
        test_reset();
        test_single_hold();
        test_conflict();
        test_interleave();
        test_reversal();
        test_release_timeout();
        test_pause();
        test_start();
        test_untracked();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
